// File: rtl/pc_stack_if.sv
// Fetch-stage program-counter bus: control-unit requests and the PC/RAS status that flows back.
interface pc_stack_if #(
  parameter int AW    = 16,
  parameter int OW    = 8,
  parameter int DEPTH = 8
);
  logic                       ld;
  logic                       incr;
  logic                       br;
  logic                       call;
  logic                       ret;
  logic                       err_clr;
  logic [AW-1:0]              Din;
  logic [OW-1:0]              offset;
  logic [AW-1:0]              Dout;
  logic [$clog2(DEPTH+1)-1:0] sp;
  logic                       full;
  logic                       empty;
  logic                       err;

  modport master (
    output ld, incr, br, call, ret, err_clr, Din, offset,
    input  Dout, sp, full, empty, err
  );

  modport slave (
    input  ld, incr, br, call, ret, err_clr, Din, offset,
    output Dout, sp, full, empty, err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack; one op per cycle, ld > call > ret > br > incr.
// Define PC_FAULT_TRAP_EN to redirect the PC to TRAP_ADDR on stack overflow/underflow.
module pc_stack #(
  parameter int             AW        = 16,
  parameter int             OW        = 8,
  parameter int             DEPTH     = 8,
  parameter logic [AW-1:0]  TRAP_ADDR = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  pc_stack_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = $clog2(DEPTH);
`ifdef PC_FAULT_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [AW-1:0]  ras [DEPTH];
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp_q;
  logic           err_q;
  logic           full, empty;
  logic           do_call, do_ret, push, pop, fault;
  logic [IW-1:0]  wr_idx, rd_idx;
  logic [AW-1:0]  off_ext, pc_inc, fault_pc;

  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign do_call  = ~bus.ld & bus.call;
  assign do_ret   = ~bus.ld & ~bus.call & bus.ret;
  assign push     = do_call & ~full;
  assign pop      = do_ret & ~empty;
  assign fault    = (do_call & full) | (do_ret & empty);
  assign wr_idx   = IW'(sp_q);
  assign rd_idx   = IW'(sp_q - SPW'(1));
  assign off_ext  = AW'($signed(bus.offset));
  assign pc_inc   = pc + AW'(1);
  // Without the trap build a fault simply holds the PC.
  assign fault_pc = TRAP_EN ? TRAP_ADDR : pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.ld)          pc <= bus.Din;
      else if (fault)      pc <= fault_pc;
      else if (push)       pc <= bus.Din;
      else if (pop)        pc <= ras[rd_idx];
      else if (bus.br)     pc <= pc + off_ext;
      else if (bus.incr)   pc <= pc_inc;

      if (push)            sp_q <= sp_q + SPW'(1);
      else if (pop)        sp_q <= sp_q - SPW'(1);

      if (fault)           err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  // Stack contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) ras[wr_idx] <= pc_inc;
  end

  assign bus.Dout  = pc;
  assign bus.sp    = sp_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.err   = err_q;
endmodule
